// File: rtl/shreg_sequencer.sv
// Command sequencer for a 4-bit shifting register: turns LOAD/SHIFT/ROTATE/XFER commands into timed ENB/DIR/S_IN/MODO/D.
// Optional abort input/flag is built when SHREG_SEQ_ABORT_EN is defined.
module shreg_sequencer #(
  parameter int         CNT_W      = 4,
  parameter logic [1:0] MODE_SHIFT = 2'b00,
  parameter logic [1:0] MODE_CIRC  = 2'b01,
  parameter logic [1:0] MODE_LOAD  = 2'b10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic             CMD_DIR,
  input  logic [3:0]       CMD_DATA,
  input  logic             CMD_SIN,
  input  logic [CNT_W-1:0] CMD_COUNT,
  output logic             ENB,
  output logic             DIR,
  output logic             S_IN,
  output logic [1:0]       MODO,
  output logic [3:0]       D,
  input  logic [3:0]       Q,
  input  logic             S_OUT,
  output logic             BUSY,
  output logic             DONE,
`ifdef SHREG_SEQ_ABORT_EN
  input  logic             ABORT,
  output logic             ABORTED,
`endif
  output logic [3:0]       RESULT
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FIN} state_e;
  typedef enum logic [1:0] {OP_LOAD, OP_SHIFT, OP_ROTATE, OP_XFER} op_e;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             dir_q, dir_d;
  logic             sin_q, sin_d;
  logic [3:0]       data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cap_q, cap_d;
  logic [3:0]       result_q, result_d;
  logic             aborted_q, aborted_d;
  logic             cmd_fire;

  assign CMD_READY = (state_q == S_IDLE) && !RST;
  assign cmd_fire  = CMD_VALID && CMD_READY;

  // NOTE: every next-state signal gets its default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dir_d     = dir_q;
    sin_d     = sin_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    cap_d     = cap_q;
    result_d  = result_q;
    aborted_d = aborted_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          op_d      = op_e'(CMD_OP);
          dir_d     = CMD_DIR;
          sin_d     = CMD_SIN;
          data_d    = CMD_DATA;
          cnt_d     = CMD_COUNT;
          aborted_d = 1'b0;
          if (op_e'(CMD_OP) == OP_LOAD || op_e'(CMD_OP) == OP_XFER) state_d = S_LOAD;
          else if (CMD_COUNT == '0)                                 state_d = S_FIN;
          else                                                      state_d = S_RUN;
        end
      end
      S_LOAD: begin
        if (op_q == OP_XFER) begin
          state_d = S_RUN;
          cnt_d   = CNT_W'(4);
        end else begin
          state_d = S_FIN;
        end
      end
      S_RUN: begin
        // S_OUT is the bit about to leave the register on this edge's shift.
        cap_d = dir_q ? {S_OUT, cap_q[3:1]} : {cap_q[2:0], S_OUT};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIN;
      end
      S_FIN: begin
        state_d  = S_IDLE;
        result_d = (op_q == OP_XFER && !aborted_q) ? cap_q : Q;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef SHREG_SEQ_ABORT_EN
    if (ABORT && (state_q == S_LOAD || state_q == S_RUN)) begin
      state_d   = S_FIN;
      aborted_d = 1'b1;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      op_q      <= OP_LOAD;
      dir_q     <= 1'b0;
      sin_q     <= 1'b0;
      data_q    <= 4'h0;
      cnt_q     <= '0;
      cap_q     <= 4'h0;
      result_q  <= 4'h0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dir_q     <= dir_d;
      sin_q     <= sin_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      cap_q     <= cap_d;
      result_q  <= result_d;
      aborted_q <= aborted_d;
    end
  end

  // Register controls come only from state and latched fields, never from CMD_* directly.
  assign ENB    = (state_q == S_LOAD) || (state_q == S_RUN);
  assign DIR    = dir_q;
  assign S_IN   = (op_q == OP_ROTATE) ? 1'b0 : sin_q;
  assign MODO   = (state_q != S_RUN)    ? MODE_LOAD :
                  (op_q == OP_ROTATE)   ? MODE_CIRC : MODE_SHIFT;
  assign D      = data_q;
  assign BUSY   = (state_q != S_IDLE);
  assign DONE   = (state_q == S_FIN);
  assign RESULT = result_q;
`ifdef SHREG_SEQ_ABORT_EN
  assign ABORTED = (state_q == S_FIN) && aborted_q;
`endif

endmodule

// File: tb/tb_shreg_sequencer.sv
// Self-checking bench for shreg_sequencer: a behavioural 4-bit register plant plus a command-level reference model.
// Define SHREG_SEQ_ABORT_EN to also exercise the abort path.
module tb_shreg_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic [1:0] CMD_OP = 2'b00;
  logic       CMD_DIR = 1'b0;
  logic [3:0] CMD_DATA = 4'h0;
  logic       CMD_SIN = 1'b0;
  logic [3:0] CMD_COUNT = 4'h0;
  logic       ENB, DIR, S_IN, BUSY, DONE;
  logic [1:0] MODO;
  logic [3:0] D, RESULT;
  logic [3:0] Q = 4'h0;
  logic       S_OUT;
`ifdef SHREG_SEQ_ABORT_EN
  logic       ABORT = 1'b0;
  logic       ABORTED;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_q = 4'h0;

  always #5 CLK = ~CLK;

  shreg_sequencer dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_DIR(CMD_DIR), .CMD_DATA(CMD_DATA), .CMD_SIN(CMD_SIN),
    .CMD_COUNT(CMD_COUNT), .ENB(ENB), .DIR(DIR), .S_IN(S_IN), .MODO(MODO), .D(D),
    .Q(Q), .S_OUT(S_OUT), .BUSY(BUSY), .DONE(DONE),
`ifdef SHREG_SEQ_ABORT_EN
    .ABORT(ABORT), .ABORTED(ABORTED),
`endif
    .RESULT(RESULT)
  );

  // Behavioural shifting register the sequencer drives.
  assign S_OUT = DIR ? Q[0] : Q[3];
  always @(posedge CLK) begin
    if (ENB) begin
      case (MODO)
        2'b00:   Q <= DIR ? {S_IN, Q[3:1]} : {Q[2:0], S_IN};
        2'b01:   Q <= DIR ? {Q[0], Q[3:1]} : {Q[2:0], Q[3]};
        2'b10:   Q <= D;
        default: Q <= Q;
      endcase
    end
  end

  // Register contents after a whole command, from closed-form arithmetic.
  function automatic logic [3:0] model_q(input logic [1:0] op, input logic dir, input logic [3:0] data,
                                         input logic sin, input int count, input logic [3:0] q);
    int v, n, fill;
    v = q;
    case (op)
      2'd0: return data;
      2'd3: return {4{sin}};
      2'd1: begin
        if (count >= 4) return {4{sin}};
        n = count;
        if (!dir) fill = sin ? ((1 << n) - 1) : 0;
        else      fill = sin ? ((15 << (4 - n)) & 15) : 0;
        return dir ? 4'((v >> n) | fill) : 4'(((v << n) | fill) & 15);
      end
      default: begin
        n = count % 4;
        return dir ? 4'(((v >> n) | (v << (4 - n))) & 15) : 4'(((v << n) | (v >> (4 - n))) & 15);
      end
    endcase
  endfunction

  task automatic run_cmd(input string name, input logic [1:0] op, input logic dir, input logic [3:0] data,
                         input logic sin, input logic [3:0] count, input bit hold_valid);
    int n_enb, done_at;
    logic [3:0] fin_q, exp_res;
    logic [3:0] exp_flags, got_flags;
    logic [3:0] exp_ctl, got_ctl;
    n_enb   = (op == 2'd0) ? 1 : (op == 2'd3) ? 5 : int'(count);
    done_at = n_enb + 1;
    fin_q   = model_q(op, dir, data, sin, int'(count), exp_q);
    exp_res = (op == 2'd3) ? data : fin_q;
    @(negedge CLK);
    CMD_OP = op; CMD_DIR = dir; CMD_DATA = data; CMD_SIN = sin; CMD_COUNT = count; CMD_VALID = 1'b1;
    n_checks++;
    if (CMD_READY !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_before: got %b expected 1", name, CMD_READY);
    end
    for (int k = 1; k <= done_at; k++) begin
      @(negedge CLK);
      if (!hold_valid || k == done_at) CMD_VALID = 1'b0;
      else begin CMD_OP = 2'($urandom_range(3)); CMD_DATA = ~data; CMD_COUNT = 4'hF; end
      exp_flags = {1'(k <= n_enb), 1'(k == done_at), 1'b1, 1'b0};
      got_flags = {ENB, DONE, BUSY, CMD_READY};
      n_checks++;
      if (got_flags !== exp_flags) begin
        n_fail++; $display("FAIL %s flags cycle %0d: ENB/DONE/BUSY/READY got %b expected %b", name, k, got_flags, exp_flags);
      end
      if (k <= n_enb) begin
        if ((op == 2'd0 || op == 2'd3) && k == 1) begin
          exp_ctl = {2'b10, 2'b00}; got_ctl = {MODO, 2'b00};
          n_checks++;
          if ({MODO, D} !== {2'b10, data}) begin
            n_fail++; $display("FAIL %s load_ctl cycle %0d: MODO/D got %b/%b expected 10/%b", name, k, MODO, D, data);
          end
        end else begin
          exp_ctl = {(op == 2'd2) ? 2'b01 : 2'b00, dir, (op == 2'd2) ? 1'b0 : sin};
          got_ctl = {MODO, DIR, S_IN};
          n_checks++;
          if (got_ctl !== exp_ctl) begin
            n_fail++; $display("FAIL %s run_ctl cycle %0d: MODO/DIR/S_IN got %b expected %b", name, k, got_ctl, exp_ctl);
          end
        end
      end
    end
    @(negedge CLK);
    n_checks++;
    if ({BUSY, CMD_READY, DONE, RESULT} !== {1'b0, 1'b1, 1'b0, exp_res}) begin
      n_fail++; $display("FAIL %s after: BUSY/READY/DONE/RESULT got %b/%b/%b/%b expected 0/1/0/%b",
                         name, BUSY, CMD_READY, DONE, RESULT, exp_res);
    end
    exp_q = fin_q;
  endtask

  task automatic test_reset();
    RST = 1'b1; CMD_VALID = 1'b1; CMD_OP = 2'd0; CMD_DATA = 4'hF;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({ENB, DIR, S_IN, MODO, D, RESULT, DONE, BUSY, CMD_READY} !== {3'b000, 2'b10, 4'h0, 4'h0, 3'b000}) begin
      n_fail++; $display("FAIL reset_values: ENB DIR S_IN MODO D RESULT DONE BUSY READY got %b %b %b %b %b %b %b %b %b",
                         ENB, DIR, S_IN, MODO, D, RESULT, DONE, BUSY, CMD_READY);
    end
    RST = 1'b0; CMD_VALID = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({CMD_READY, BUSY, ENB} !== 3'b100) begin
      n_fail++; $display("FAIL reset_release: READY/BUSY/ENB got %b%b%b expected 100", CMD_READY, BUSY, ENB);
    end
  endtask

  task automatic test_load();
    run_cmd("load_1010", 2'd0, 1'b0, 4'b1010, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_rotate();
    run_cmd("load_0001", 2'd0, 1'b0, 4'b0001, 1'b0, 4'd0, 1'b0);
    run_cmd("rotate_r5", 2'd2, 1'b1, 4'b0000, 1'b1, 4'd5, 1'b0);
    n_checks++;
    if (RESULT !== 4'b1000) begin
      n_fail++; $display("FAIL rotate_r5_result: got %b expected 1000", RESULT);
    end
  endtask

  task automatic test_count_zero();
    run_cmd("shift_cnt0", 2'd1, 1'b0, 4'b0000, 1'b1, 4'd0, 1'b0);
    run_cmd("shift_busy_valid", 2'd1, 1'b0, 4'b0000, 1'b1, 4'd3, 1'b1);
  endtask

  task automatic test_xfer();
    run_cmd("xfer_left", 2'd3, 1'b0, 4'b1101, 1'b0, 4'd0, 1'b0);
    run_cmd("xfer_right", 2'd3, 1'b1, 4'b1101, 1'b1, 4'd0, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    CMD_OP = 2'd1; CMD_DIR = 1'b0; CMD_SIN = 1'b1; CMD_COUNT = 4'd8; CMD_VALID = 1'b1;
    @(negedge CLK); CMD_VALID = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (ENB !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pre: ENB got %b expected 1", ENB);
    end
    RST = 1'b1;
    #1;
    n_checks++;
    if ({ENB, BUSY, DONE} !== 3'b000) begin
      n_fail++; $display("FAIL midreset_async: ENB/BUSY/DONE got %b%b%b expected 000", ENB, BUSY, DONE);
    end
    @(negedge CLK); RST = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      n_checks++;
      if ({DONE, BUSY, RESULT} !== {2'b00, 4'h0}) begin
        n_fail++; $display("FAIL midreset_after cycle %0d: DONE/BUSY/RESULT got %b%b/%b expected 00/0000", k, DONE, BUSY, RESULT);
      end
    end
    run_cmd("reload_after_reset", 2'd0, 1'b0, 4'b0110, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      run_cmd("random", 2'($urandom_range(3)), 1'($urandom_range(1)), 4'($urandom_range(15)),
              1'($urandom_range(1)), 4'($urandom_range(15)), 1'($urandom_range(1)));
    end
  endtask

`ifdef SHREG_SEQ_ABORT_EN
  task automatic test_abort();
    logic [3:0] exp_res;
    exp_res = model_q(2'd1, 1'b0, 4'h0, 1'b1, 3, exp_q);
    @(negedge CLK);
    CMD_OP = 2'd1; CMD_DIR = 1'b0; CMD_SIN = 1'b1; CMD_COUNT = 4'd10; CMD_VALID = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      CMD_VALID = 1'b0;
      ABORT = (k == 3);
      n_checks++;
      if ({ENB, DONE, ABORTED} !== {1'(k <= 3), 1'(k == 4), 1'(k == 4)}) begin
        n_fail++; $display("FAIL abort cycle %0d: ENB/DONE/ABORTED got %b%b%b", k, ENB, DONE, ABORTED);
      end
    end
    n_checks++;
    if (RESULT !== exp_res) begin
      n_fail++; $display("FAIL abort_result: got %b expected %b", RESULT, exp_res);
    end
    exp_q = exp_res;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_rotate();
    test_count_zero();
    test_xfer();
`ifdef SHREG_SEQ_ABORT_EN
    test_abort();
`endif
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
